layer_addr_seq: RTL
===================

# layer_addr_seq

Parametrised address sequencer for one fully-connected layer of the MLP datapath. It streams weight and input SRAM addresses neuron-group by neuron-group and tags the returning data with first/last markers aligned to SRAM read latency. It pulses `mac_start` at the end of each group and waits for the sigmoid stage's ready handshake before starting the next group. It replaces hand-driven address counters and makes layer size, lane count and read latency configurable.

## Interface
Parameters:
- `N_IN`, 784: maximum inputs per neuron.
- `N_OUT`, 200: maximum neurons per layer.
- `LANES`, 10: neurons computed in parallel. One weight bank and one MAC per lane.
- `RD_LAT`, 1: SRAM read latency in cycles, at least 1.
- `W_AW`, 18: weight address width. Must hold `N_IN*ceil(N_OUT/LANES)-1`.
- `X_AW`, 10: input address width.

Ports:
- `clk` in 1: clock. One clock domain; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: sampled only in IDLE. Latches `cfg_n_in` and `cfg_n_out`.
- `cfg_n_in` in X_AW+1: inputs per neuron for this run.
- `cfg_n_out` in 9: neurons for this run.
- `hold` in 1: stalls address generation.
- `acc_ack` in 1: sigmoid or consumer ready (`sig_ready`). Sampled only in WAIT.
- `w_addr` out W_AW: weight address, common to all lane banks.
- `x_addr` out X_AW: input SRAM address.
- `addr_valid` out 1: address pair is valid this cycle.
- `dat_valid`, `dat_first`, `dat_last` out 1 each: tags delayed `RD_LAT` cycles to align with SRAM data.
- `lane_mask` out LANES: active lanes for the current group.
- `group` out 8: current group index.
- `mac_start` out 1: one-cycle pulse per group.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `err` out 1: set with `done` on an invalid config; cleared on the next `start`.

## Operation
- States: IDLE, STREAM, DRAIN, FIRE, WAIT, FINISH.
- Config check at `start`:
  - Valid means `1<=cfg_n_in<=N_IN` and `1<=cfg_n_out<=N_OUT`.
  - Invalid config: go to FINISH with `err=1`. No addresses are issued.
- `G = ceil(cfg_n_out/LANES)` groups. Weight layout is neuron-major; bank `l` holds neuron `g*LANES+l`.
- Address generation:
  - `x_addr = k`.
  - `w_addr = base + k`. `base` is an accumulator, cleared at `start` and incremented by `cfg_n_in` after each group. No multiplier.
- STREAM: one address per cycle, `k = 0..cfg_n_in-1`.
  - `hold=1`: `addr_valid=0`, `k` is frozen, and the tag pipeline keeps shifting, so a bubble propagates.
- After `k = cfg_n_in-1` is issued, go to DRAIN for `RD_LAT` cycles, so that `dat_last` has been emitted.
- FIRE: `mac_start=1` for one cycle, then go to WAIT.
- WAIT:
  - `acc_ack=1` on the last group: go to FINISH.
  - `acc_ack=1` otherwise: `group++`, `base += cfg_n_in`, `k=0`, go to STREAM.
- FINISH: `done=1` for one cycle, then go to IDLE.
- `lane_mask` bit `l` is set iff `g*LANES + l < cfg_n_out`.
- Ignored inputs: `start` while busy; `acc_ack` outside WAIT; `hold` outside STREAM.

## Timing
- Reset (async): state IDLE, all outputs 0, counters 0, `err` 0.
- `start` sampled at edge 0: first `addr_valid` is asserted in cycle 1 with `k=0`.
- Tag alignment:
  - `dat_first` rises exactly `RD_LAT` cycles after the `k=0` address.
  - `dat_last` rises exactly `RD_LAT` cycles after the `k=cfg_n_in-1` address.
- `mac_start` is the cycle after `dat_last`.
- Group cycle count with no stall: `cfg_n_in + RD_LAT + 1` cycles, plus WAIT time.
- Next group's `k=0` address is issued the cycle after `acc_ack` is sampled.
- `done` is asserted the cycle after the final `acc_ack`, or 1 cycle after `start` on an invalid config.
- Reset mid-run:
  - Immediate return to IDLE; in-flight tags are discarded.
  - The next `start` begins at group 0, address 0.

## Structure
- Package `layer_seq_pkg`:
  - State enum.
  - `CFG_OUT_W=9`.
  - Default parameter constants.
  - `ceil_div` function.
- Sub-module `tag_pipe`: `RD_LAT`-deep shift register carrying {valid, first, last}, with async reset.

## Test plan
1. Defaults, `cfg_n_in=784`, `cfg_n_out=200`, prompt `acc_ack`:
   - 20 groups; group 1 first `w_addr=784`; final `w_addr=15679`.
   - 20 `mac_start` pulses; one `done`; 784 `dat_valid` per group.
2. `cfg_n_out=25`: 3 groups with `lane_mask` `0x3FF`, `0x3FF`, `0x01F`.
3. `RD_LAT=2`, `cfg_n_in=8`, `hold` high for 3 cycles at `k=4`:
   - `addr_valid` low for 3 cycles; `k` sequence 0..7 with no skip or duplicate.
   - `dat_last` 2 cycles after `k=7`.
4. Invalid configs: `cfg_n_in=0` gives `done` and `err` 1 cycle after `start`, with no `addr_valid`. `cfg_n_out=201` gives the same.
5. Reset asserted mid-STREAM of group 3: outputs are 0 in the same cycle; a new `start` issues `w_addr=0`, `group=0`.
6. Ignored inputs:
   - `start` pulsed while busy: no effect.
   - `acc_ack` during STREAM or DRAIN: no group advance.
   - `acc_ack` held high in WAIT: advances exactly one group per WAIT entry.

Source files
------------

// File: rtl/layer_addr_seq_pkg.sv
// Shared types and constants for the layer address sequencer.
package layer_seq_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FIRE   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FINISH = 3'd5
    } seq_state_t;

    // Width of the neurons-per-run configuration field.
    localparam int CFG_OUT_W  = 9;
    // Width of the group index output.
    localparam int GROUP_W    = 8;
    // Tag bundle carried alongside SRAM reads: {valid, first, last}.
    localparam int TAG_W      = 3;

    // Default geometry of the layer.
    localparam int DEF_N_IN   = 784;
    localparam int DEF_N_OUT  = 200;
    localparam int DEF_LANES  = 10;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_W_AW   = 18;
    localparam int DEF_X_AW   = 10;

    // Integer ceiling division, used for the group count.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/layer_addr_seq_if.sv
// Control, address and tag bundle between the sequencer and its host.
interface layer_addr_seq_if
    import layer_seq_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W_AW  = DEF_W_AW,
    parameter int X_AW  = DEF_X_AW
) ();

    logic                 start;
    logic [X_AW:0]        cfg_n_in;
    logic [CFG_OUT_W-1:0] cfg_n_out;
    logic                 hold;
    logic                 acc_ack;
    logic [W_AW-1:0]      w_addr;
    logic [X_AW-1:0]      x_addr;
    logic                 addr_valid;
    logic                 dat_valid;
    logic                 dat_first;
    logic                 dat_last;
    logic [LANES-1:0]     lane_mask;
    logic [GROUP_W-1:0]   group;
    logic                 mac_start;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Sequencer side: issues addresses and tags.
    modport master (
        input  start, cfg_n_in, cfg_n_out, hold, acc_ack,
        output w_addr, x_addr, addr_valid, dat_valid, dat_first, dat_last,
               lane_mask, group, mac_start, busy, done, err
    );

    // Host side: configures runs and consumes addresses and tags.
    modport slave (
        output start, cfg_n_in, cfg_n_out, hold, acc_ack,
        input  w_addr, x_addr, addr_valid, dat_valid, dat_first, dat_last,
               lane_mask, group, mac_start, busy, done, err
    );

endinterface

// File: rtl/layer_addr_seq_tag_pipe.sv
// Fixed-depth delay line that realigns address tags with SRAM read data.
module tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int TW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] tag_in,
    output logic [TW-1:0] tag_out
);

    logic [TW-1:0] stage_reg [RD_LAT];

    // Shift every cycle; a reset discards whatever is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tag_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/layer_addr_seq.sv
// Address sequencer for one fully-connected layer: walks the weight and
// input SRAMs group by group, tags the returning data, and hands each
// finished group to the MAC/sigmoid stage.
module layer_addr_seq
    import layer_seq_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int LANES  = DEF_LANES,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int W_AW   = DEF_W_AW,
    parameter int X_AW   = DEF_X_AW
) (
    input  logic             clk,
    input  logic             reset,
    layer_addr_seq_if.master bus
);

    localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int NB_W    = 16;
    localparam logic [X_AW:0]        N_IN_L     = (X_AW+1)'(N_IN);
    localparam logic [CFG_OUT_W-1:0] N_OUT_L    = CFG_OUT_W'(N_OUT);
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(RD_LAT - 1);

    seq_state_t           state_reg,    state_next;
    logic [X_AW-1:0]      k_reg,        k_next;
    logic [W_AW-1:0]      base_reg,     base_next;
    logic [NB_W-1:0]      nbase_reg,    nbase_next;
    logic [GROUP_W-1:0]   group_reg,    group_next;
    logic [GROUP_W-1:0]   n_groups_reg, n_groups_next;
    logic [X_AW:0]        n_in_reg,     n_in_next;
    logic [CFG_OUT_W-1:0] n_out_reg,    n_out_next;
    logic [DRAIN_W-1:0]   drain_reg,    drain_next;
    logic                 err_reg,      err_next;

    logic                 addr_valid_c;
    logic                 cfg_ok;
    logic [X_AW:0]        last_k;
    logic                 k_is_last;
    logic                 mask_en;
    logic [LANES-1:0]     lane_mask_c;
    logic [TAG_W-1:0]     tag_in;
    logic [TAG_W-1:0]     tag_out;

    // Configuration is accepted only when both sizes fit the built geometry.
    assign cfg_ok = (bus.cfg_n_in  != '0) && (bus.cfg_n_in  <= N_IN_L) &&
                    (bus.cfg_n_out != '0) && (bus.cfg_n_out <= N_OUT_L);

    assign last_k    = n_in_reg - {{X_AW{1'b0}}, 1'b1};
    assign k_is_last = ({1'b0, k_reg} == last_k);

    // State and datapath registers; reset drops straight back to an idle, zeroed sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            k_reg        <= '0;
            base_reg     <= '0;
            nbase_reg    <= '0;
            group_reg    <= '0;
            n_groups_reg <= '0;
            n_in_reg     <= '0;
            n_out_reg    <= '0;
            drain_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            base_reg     <= base_next;
            nbase_reg    <= nbase_next;
            group_reg    <= group_next;
            n_groups_reg <= n_groups_next;
            n_in_reg     <= n_in_next;
            n_out_reg    <= n_out_next;
            drain_reg    <= drain_next;
            err_reg      <= err_next;
        end
    end

    // Next-state and counter updates. The weight base advances by one
    // neuron's worth of inputs per group, so no multiplier is needed.
    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        base_next     = base_reg;
        nbase_next    = nbase_reg;
        group_next    = group_reg;
        n_groups_next = n_groups_reg;
        n_in_next     = n_in_reg;
        n_out_next    = n_out_reg;
        drain_next    = drain_reg;
        err_next      = err_reg;
        addr_valid_c  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    n_in_next     = bus.cfg_n_in;
                    n_out_next    = bus.cfg_n_out;
                    n_groups_next = GROUP_W'(ceil_div(int'(bus.cfg_n_out), LANES));
                    k_next        = '0;
                    base_next     = '0;
                    nbase_next    = '0;
                    group_next    = '0;
                    err_next      = !cfg_ok;
                    state_next    = cfg_ok ? ST_STREAM : ST_FINISH;
                end
            end
            ST_STREAM: begin
                // A held cycle issues nothing and leaves k where it is.
                if (!bus.hold) begin
                    addr_valid_c = 1'b1;
                    if (k_is_last) begin
                        drain_next = DRAIN_LOAD;
                        state_next = ST_DRAIN;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait out the read latency so the last tag has left the pipe.
                if (drain_reg == '0) begin
                    state_next = ST_FIRE;
                end else begin
                    drain_next = drain_reg - 1'b1;
                end
            end
            ST_FIRE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.acc_ack) begin
                    if (group_reg == n_groups_reg - 1'b1) begin
                        state_next = ST_FINISH;
                    end else begin
                        group_next = group_reg + 1'b1;
                        base_next  = base_reg + W_AW'(n_in_reg);
                        nbase_next = nbase_reg + NB_W'(LANES);
                        k_next     = '0;
                        state_next = ST_STREAM;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Lanes whose neuron index falls past the configured layer size stay off.
    assign mask_en = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN) ||
                     (state_reg == ST_FIRE)   || (state_reg == ST_WAIT);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_mask_c[gi] = mask_en && ((nbase_reg + NB_W'(gi)) < NB_W'(n_out_reg));
    end

    assign tag_in = {addr_valid_c,
                     addr_valid_c && (k_reg == '0),
                     addr_valid_c && k_is_last};

    tag_pipe #(
        .RD_LAT (RD_LAT),
        .TW     (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.w_addr     = base_reg + W_AW'(k_reg);
    assign bus.x_addr     = k_reg;
    assign bus.addr_valid = addr_valid_c;
    assign bus.dat_valid  = tag_out[2];
    assign bus.dat_first  = tag_out[1];
    assign bus.dat_last   = tag_out[0];
    assign bus.lane_mask  = lane_mask_c;
    assign bus.group      = group_reg;
    assign bus.mac_start  = (state_reg == ST_FIRE);
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.done       = (state_reg == ST_FINISH);
    assign bus.err        = err_reg;

endmodule
